// File: rtl/io_input_unit.sv
// io_input_unit: services an IN instruction by stalling the CPU until the operator
//    presses and releases Enter, then drives the captured switch value on DataIO.
// Latency: capture DEBOUNCE_CYCLES+2 cycles after a clean Enter press; Ready pulses
//    DEBOUNCE_CYCLES+2 cycles after a clean release.
// Backpressure: Halt stalls the pipeline while the request is pending; it drops for
//    exactly the one DONE cycle, and that cycle carries the Ready pulse.
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous active-low reset
//   InputReq  control unit is executing an IN instruction
//   Switches  board switches (quasi-static), SW_WIDTH bits
//   Enter     raw asynchronous bouncing push-button, active-high
//   DataIO    32-bit captured value for the writeback select
//   Halt      stall request, combinational from state and InputReq
//   Ready     registered one-cycle pulse, DataIO may be committed
module io_input_unit #(
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SIGN_EXTEND     = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                InputReq,
   input  logic [SW_WIDTH-1:0] Switches,
   input  logic                Enter,
   output logic [31:0]         DataIO,
   output logic                Halt,
   output logic                Ready
);

   // Counter only needs to reach DEBOUNCE_CYCLES-1: the edge where it would
   // reach DEBOUNCE_CYCLES is the edge where the stable level is updated.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      DONE         = 2'd3
   } state_t;

   state_t          state;
   logic            enter_s1;
   logic            enter_s2;
   logic            enter_stable;
   logic [CW-1:0]   deb_cnt;
   logic [1:0]      warm;
   logic            armed;
   logic            deb_done;
   logic            enter_rise;
   logic            enter_fall;
   logic [31:0]     ext_val;

   // ------------------------------------------------------------------
   // Switch extension to 32 bits
   // ------------------------------------------------------------------
   if (SW_WIDTH < 32) begin : g_ext
      logic fill;
      assign fill    = (SIGN_EXTEND != 0) & Switches[SW_WIDTH-1];
      assign ext_val = {{(32-SW_WIDTH){fill}}, Switches};
   end else begin : g_copy
      assign ext_val = Switches[31:0];
   end

   // ------------------------------------------------------------------
   // Enter conditioning: 2-flop synchronizer + level debouncer
   // ------------------------------------------------------------------
   // The level change is accepted on the edge where the counter has already
   // seen DEBOUNCE_CYCLES-1 mismatching cycles and the mismatch persists.
   assign deb_done   = (enter_s2 != enter_stable) && (deb_cnt == CNT_LAST);
   assign enter_rise = deb_done & enter_s2;
   assign enter_fall = deb_done & ~enter_s2;

   always_ff @(posedge clock) begin
      if (!reset) begin
         enter_s1     <= 1'b0;
         enter_s2     <= 1'b0;
         enter_stable <= 1'b0;
         deb_cnt      <= '0;
         warm         <= 2'b00;
         armed        <= 1'b0;
      end else begin
         enter_s1 <= Enter;
         enter_s2 <= enter_s1;

         if (enter_s2 == enter_stable) begin
            deb_cnt <= '0;
         end else if (deb_done) begin
            enter_stable <= enter_s2;
            deb_cnt      <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end

         // The synchronizer holds reset zeros for two cycles, which would
         // look like a released button. Only after that can a genuinely
         // released Enter arm capture; a button held through reset then
         // debounces to a rise that is not treated as a press.
         warm <= {warm[0], 1'b1};
         if (warm[1] && !enter_s2 && !enter_stable) begin
            armed <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Request FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         DataIO <= '0;
         Ready  <= 1'b0;
      end else begin
         Ready <= 1'b0;
         case (state)
            IDLE: begin
               if (InputReq) begin
                  state <= WAIT_PRESS;
               end
            end
            WAIT_PRESS: begin
               // A withdrawn request wins over a coincident press.
               if (!InputReq) begin
                  state <= IDLE;
               end else if (enter_rise && armed) begin
                  DataIO <= ext_val;
                  state  <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (!InputReq) begin
                  state <= IDLE;
               end else if (enter_fall) begin
                  state <= DONE;
                  Ready <= 1'b1;
               end
            end
            DONE: begin
               // InputReq here belongs to the retiring instruction.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign Halt = reset & (((state == IDLE) & InputReq) |
                          (state == WAIT_PRESS) |
                          (state == WAIT_RELEASE));

endmodule

// File: doc/io_input_unit.md
Name: io_input_unit

Overview:
- Producer side of the register-writeback DataIO path.
- Services an IN instruction: stalls the CPU, waits for the operator to set the board switches and press/release the Enter button, then latches the switch value onto DataIO.
- Releases the stall for exactly one cycle so the writeback stage can commit DataIO.
- Sits between board I/O pins and the datapath; driven by control-unit InputReq.

Parameters:
- SW_WIDTH, 16, number of switch bits captured (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept an Enter level change (>=1).
- SIGN_EXTEND, 0, 0 = zero-extend the switch value to 32 bits; 1 = sign-extend from bit SW_WIDTH-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- InputReq  input  1  control unit is executing an IN instruction.
- Switches  input  SW_WIDTH  board switches, quasi-static.
- Enter  input  1  raw push-button, asynchronous, bouncing, active-high.
- DataIO  output  32  captured input value presented to the writeback select.
- Halt  output  1  stall request to PC/pipeline; combinational from state and InputReq.
- Ready  output  1  registered one-cycle pulse; DataIO is valid to commit this cycle.

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE; DataIO=0; Ready=0.
  - Sync flops=0, debounced EnterStable=0, debounce counter=0.
  - Halt=0 while in reset.
  - Reset mid-operation aborts any capture; no Ready pulse.
- Enter conditioning:
  - Two-flop synchronizer feeds the debounce logic.
  - Counter increments while synchronized value != EnterStable; clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, EnterStable takes the synchronized value and the counter clears.
  - EnterRise/EnterFall are one-cycle pulses when EnterStable changes.
  - Total latency from a clean Enter edge to the pulse: DEBOUNCE_CYCLES+2 cycles.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
  - IDLE: InputReq=1 -> WAIT_PRESS; otherwise stay.
  - WAIT_PRESS: InputReq=0 -> IDLE (flush abort, DataIO unchanged). EnterRise -> capture, then WAIT_RELEASE.
  - Capture: DataIO <= Switches, extended per SIGN_EXTEND, sampled at the same edge as EnterRise.
  - Enter already held (EnterStable=1) on entry to WAIT_PRESS does not capture; a release followed by a new press is required.
  - WAIT_RELEASE: InputReq=0 -> IDLE (DataIO keeps the captured value, no Ready). EnterFall -> DONE.
  - DONE: Ready=1 for this single cycle, then IDLE unconditionally. InputReq still high in DONE is the retiring instruction and is ignored.
  - A new IN instruction in the following cycle (IDLE with InputReq=1) restarts the sequence.
- Halt = (state==IDLE & InputReq) | state==WAIT_PRESS | state==WAIT_RELEASE.
  - Halt=0 in DONE, so the pipeline advances exactly one instruction with DataIO stable.
- DataIO holds its value between captures and changes only on a capture edge or reset.
- Switch changes after the capture edge have no effect until the next capture.
- SW_WIDTH=32 with either SIGN_EXTEND setting is a direct copy.

Test Plan (DEBOUNCE_CYCLES=4, SW_WIDTH=16):
- Reset: hold reset=0 for 3 cycles with InputReq=1 and Enter=1 -> DataIO=0, Halt=0, Ready=0. Release reset -> Halt=1 immediately; no capture while Enter is held.
- Normal IN, SIGN_EXTEND=0:
  - Stimulus: InputReq=1, Switches=16'h8123, clean Enter pulse 10 cycles wide.
  - Response: Halt=1 until DONE; DataIO=32'h00008123 6 cycles after the press.
  - Ready=1 for one cycle with Halt=0, 6 cycles after release; then IDLE.
- Sign extension: SIGN_EXTEND=1, Switches=16'h8123 -> DataIO=32'hFFFF8123. Switches=16'h7FFF -> DataIO=32'h00007FFF.
- Bounce: Enter toggles every 2 cycles for 12 cycles, then stays high -> exactly one capture 6 cycles after it settles. Switches changed during the bounce are taken at that edge only.
- Abort: drop InputReq in WAIT_PRESS -> IDLE, Halt=0, DataIO unchanged, no Ready. Drop InputReq in WAIT_RELEASE -> IDLE, DataIO retains the new value, no Ready.
- Back-to-back IN: InputReq stays high through DONE and into the next cycle -> Ready pulses once, and Halt reasserts in the IDLE cycle. The second capture requires a fresh press and gets new Switches=16'h0042 -> DataIO=32'h00000042.
